// File: rtl/fftrx_pkg.sv
// Shared types and default widths for the FFT-core output receiver.
// Latency: none (definitions only). Backpressure: none.
package fftrx_pkg;
    localparam int BW_NUMELM = 6;
    localparam int BW_DATA   = 16;
    localparam int NBINS     = 1 << BW_NUMELM;
    localparam int BW_MAG    = BW_DATA + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INPUT    = 2'd1,
        WAIT_OUT = 2'd2,
        UNLOAD   = 2'd3
    } state_t;
endpackage

// File: rtl/fftrx_absmag.sv
// Registered |re|+|im| magnitude stage carrying a write-address tag alongside.
// Latency: 1 cycle. Backpressure: none, one result per valid input.
module fftrx_absmag #(
    parameter int bw_data = 16,
    parameter int bw_tag  = 7
) (
    input  logic                      Clock,
    input  logic                      nReset,
    input  logic                      in_vld,
    input  logic signed [bw_data-1:0] re,
    input  logic signed [bw_data-1:0] im,
    input  logic [bw_tag-1:0]         tag_in,
    output logic                      out_vld,
    output logic [bw_data:0]          mag,
    output logic [bw_tag-1:0]         tag
);
    logic signed [bw_data:0] re_x;
    logic signed [bw_data:0] im_x;
    logic [bw_data:0]        re_a;
    logic [bw_data:0]        im_a;

    // One extra bit so that the most negative input has a representable magnitude.
    assign re_x = {re[bw_data-1], re};
    assign im_x = {im[bw_data-1], im};
    assign re_a = re_x[bw_data] ? -re_x : re_x;
    assign im_a = im_x[bw_data] ? -im_x : im_x;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            out_vld <= 1'b0;
            mag     <= '0;
            tag     <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                mag <= re_a + im_a;
                tag <= tag_in;
            end
        end
    end
endmodule

// File: rtl/fftc_out_receiver.sv
// FFT-core output receiver: framing FSM, bin index check, ping-pong bank control; optional peak tracker under FFTRX_PEAK_EN.
// Latency: bin to wr_en 1 cycle, frame_ready 2 cycles after last bin. Backpressure: none, the core cannot be stalled.
module fftc_out_receiver
    import fftrx_pkg::*;
#(
    parameter int bw_numelm = BW_NUMELM,
    parameter int bw_data   = BW_DATA
) (
    input  logic                        Clock,
    input  logic                        nReset,
    input  logic                        ibstart,
    input  logic                        ibend,
    input  logic                        obstart,
    input  logic                        outvalid,
    input  logic [bw_numelm-1:0]        NumElm,
    input  logic signed [bw_data-1:0]   XkRe,
    input  logic signed [bw_data-1:0]   XkIm,
    input  logic                        err_clr,
    output logic                        wr_en,
    output logic [bw_numelm:0]          wr_addr,
    output logic [bw_data:0]            wr_data,
    output logic                        rd_bank,
    output logic                        frame_ready,
    output logic                        busy,
    output logic                        seq_err
`ifdef FFTRX_PEAK_EN
    ,
    output logic [bw_numelm-1:0]        peak_bin,
    output logic [bw_data:0]            peak_mag
`endif
);
    localparam logic [bw_numelm-1:0] LAST_IDX = '1;

    state_t               state, nxt_state;
    logic [bw_numelm-1:0] exp_idx, nxt_idx;
    logic                 wbank;
    logic                 take, last, viol, ob_acc;
    logic                 last_q;
    logic                 idx_ok;

    assign idx_ok = (NumElm == exp_idx);
    assign busy   = (state != IDLE);

    always_comb begin
        nxt_state = state;
        nxt_idx   = exp_idx;
        take      = 1'b0;
        last      = 1'b0;
        viol      = 1'b0;
        ob_acc    = 1'b0;
        case (state)
            IDLE: begin
                if (ibstart) nxt_state = INPUT;
                if (obstart || ibend) viol = 1'b1;
            end
            INPUT: begin
                if (ibstart) viol = 1'b1;
                else if (ibend) nxt_state = WAIT_OUT;
                if (obstart) viol = 1'b1;
            end
            WAIT_OUT: begin
                if (ibstart) begin
                    viol      = 1'b1;
                    nxt_state = INPUT;
                end else if (obstart && outvalid) begin
                    ob_acc = 1'b1;
                    if (idx_ok) begin
                        take      = 1'b1;
                        nxt_idx   = exp_idx + 1'b1;
                        nxt_state = UNLOAD;
                    end else begin
                        viol      = 1'b1;
                        nxt_state = IDLE;
                    end
                end
                if (ibend) viol = 1'b1;
            end
            UNLOAD: begin
                // A restart landing on the final good bin is a back-to-back frame, not an error.
                if (obstart) begin
                    viol      = 1'b1;
                    nxt_state = IDLE;
                end else if (ibstart && !(outvalid && idx_ok && exp_idx == LAST_IDX)) begin
                    viol      = 1'b1;
                    nxt_state = INPUT;
                end else if (outvalid) begin
                    if (idx_ok) begin
                        take    = 1'b1;
                        nxt_idx = exp_idx + 1'b1;
                        if (exp_idx == LAST_IDX) begin
                            last      = 1'b1;
                            nxt_state = ibstart ? INPUT : IDLE;
                        end
                    end else begin
                        viol      = 1'b1;
                        nxt_state = IDLE;
                    end
                end
                if (ibend) viol = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
        if (nxt_state != UNLOAD) nxt_idx = '0;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            exp_idx     <= '0;
            wbank       <= 1'b1;
            rd_bank     <= 1'b0;
            last_q      <= 1'b0;
            frame_ready <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= nxt_state;
            exp_idx     <= nxt_idx;
            last_q      <= last;
            frame_ready <= last_q;
            if (viol) seq_err <= 1'b1;
            else if (err_clr) seq_err <= 1'b0;
            if (last_q) begin
                rd_bank <= wbank;
                wbank   <= ~wbank;
            end
        end
    end

    fftrx_absmag #(
        .bw_data (bw_data),
        .bw_tag  (bw_numelm + 1)
    ) u_absmag (
        .Clock   (Clock),
        .nReset  (nReset),
        .in_vld  (take),
        .re      (XkRe),
        .im      (XkIm),
        .tag_in  ({wbank, NumElm}),
        .out_vld (wr_en),
        .mag     (wr_data),
        .tag     (wr_addr)
    );

`ifdef FFTRX_PEAK_EN
    logic [bw_numelm-1:0] pk_bin, pk_bin_nxt;
    logic [bw_data:0]     pk_mag, pk_mag_nxt;

    always_comb begin
        pk_bin_nxt = pk_bin;
        pk_mag_nxt = pk_mag;
        if (wr_en && wr_data > pk_mag) begin
            pk_bin_nxt = wr_addr[bw_numelm-1:0];
            pk_mag_nxt = wr_data;
        end
    end

    // The final write is folded in on the same edge that publishes the frame.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pk_bin   <= '0;
            pk_mag   <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
        end else begin
            if (ob_acc) begin
                pk_bin <= '0;
                pk_mag <= '0;
            end else begin
                pk_bin <= pk_bin_nxt;
                pk_mag <= pk_mag_nxt;
            end
            if (last_q) begin
                peak_bin <= pk_bin_nxt;
                peak_mag <= pk_mag_nxt;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fftc_out_receiver.sv
// Directed bench for fftc_out_receiver: per-cycle vector table plus hand sequences for reset and peak.
module tb_fftc_out_receiver;
    logic               Clock = 1'b0;
    logic               nReset;
    logic               ibstart, ibend, obstart, outvalid, err_clr;
    logic [5:0]         NumElm;
    logic signed [15:0] XkRe, XkIm;
    logic               wr_en, rd_bank, frame_ready, busy, seq_err;
    logic [6:0]         wr_addr;
    logic [16:0]        wr_data;
`ifdef FFTRX_PEAK_EN
    logic [5:0]         peak_bin;
    logic [16:0]        peak_mag;
`endif

    always #5 Clock = ~Clock;

    fftc_out_receiver dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .ibstart     (ibstart),
        .ibend       (ibend),
        .obstart     (obstart),
        .outvalid    (outvalid),
        .NumElm      (NumElm),
        .XkRe        (XkRe),
        .XkIm        (XkIm),
        .err_clr     (err_clr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_bank     (rd_bank),
        .frame_ready (frame_ready),
        .busy        (busy),
        .seq_err     (seq_err)
`ifdef FFTRX_PEAK_EN
        ,
        .peak_bin    (peak_bin),
        .peak_mag    (peak_mag)
`endif
    );

    typedef struct {
        logic        ib, ie, ob, ov;
        logic [5:0]  n;
        logic [15:0] re, im;
        logic        clr;
        logic        we;
        logic [6:0]  wa;
        logic [16:0] wd;
        logic        rb, fr, bz, se;
    } vec_t;

    vec_t tbl[$];
    int   nvec  = 0;
    int   nmiss = 0;

    task automatic add(input logic ib, ie, ob, ov, input logic [5:0] n,
                       input logic [15:0] re, im, input logic clr,
                       input logic we, input logic [6:0] wa, input logic [16:0] wd,
                       input logic rb, fr, bz, se);
        vec_t v;
        v.ib = ib; v.ie = ie; v.ob = ob; v.ov = ov; v.n = n; v.re = re; v.im = im;
        v.clr = clr; v.we = we; v.wa = wa; v.wd = wd;
        v.rb = rb; v.fr = fr; v.bz = bz; v.se = se;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic ib, ie, clr, rb, bz, se);
        add(ib, ie, 1'b0, 1'b0, 6'd0, 16'd0, 16'd0, clr, 1'b0, 7'd0, 17'd0, rb, 1'b0, bz, se);
    endtask

    // Full 64-bin frame from WAIT_OUT with XkRe=k, XkIm=-k, followed by three trailing rows.
    task automatic add_bins(input logic bank, rd0, err, wrap, ext, iblast);
        logic [6:0]  pa;
        logic [16:0] pd;
        logic [15:0] re, im;
        logic [16:0] d;
        pa = '0;
        pd = '0;
        for (int k = 0; k < 64; k++) begin
            re = 16'(k);
            im = 16'(-k);
            d  = 17'(2 * k);
            if (ext && k == 5) begin
                re = 16'h8000;
                im = 16'h8000;
                d  = 17'd65536;
            end
            add(iblast && k == 63, 1'b0, k == 0, 1'b1, 6'(k), re, im, 1'b0,
                k > 0, pa, pd, rd0, 1'b0, 1'b1, err);
            pa = {bank, 6'(k)};
            pd = d;
        end
        add(1'b0, 1'b0, 1'b0, wrap, 6'd0, 16'd7, 16'd7, 1'b0, 1'b1, pa, pd, rd0, 1'b0, iblast, err);
        add(1'b0, 1'b0, 1'b0, wrap, 6'd1, 16'd7, 16'd7, 1'b0, 1'b0, 7'd0, 17'd0, bank, 1'b1, iblast, err);
        add(1'b0, 1'b0, 1'b0, wrap, 6'd2, 16'd7, 16'd7, 1'b0, 1'b0, 7'd0, 17'd0, bank, 1'b0, iblast, err);
    endtask

    task automatic drive(input logic ib, ie, ob, ov, input logic [5:0] n,
                         input logic [15:0] re, im, input logic clr);
        ibstart = ib; ibend = ie; obstart = ob; outvalid = ov;
        NumElm = n; XkRe = re; XkIm = im; err_clr = clr;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmiss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    initial begin
        logic ok;
        logic got;

        nReset = 1'b0;
        drive(0, 0, 0, 0, 6'd0, 16'd0, 16'd0, 0);
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;

        // Clean frame into bank 1
        add_idle(0, 0, 0, 0, 0, 0);
        add_idle(1, 0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 1, 0);
        add_bins(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Bank 0 frame with extreme bin 5 and a source that keeps outvalid high
        add_idle(1, 0, 0, 1, 0, 0);
        add_idle(0, 1, 0, 1, 1, 0);
        add_bins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Index skip 9 -> 11, then err_clr, then err_clr racing a new violation
        add_idle(1, 0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'b0, k == 0, 1'b1, 6'(k), 16'(k), 16'(-k), 1'b0,
                k > 0, {1'b1, 6'(k - 1)}, 17'(2 * (k - 1)), 1'b0, 1'b0, 1'b1, 1'b0);
        add(0, 0, 0, 1, 6'd11, 16'd11, 16'(-11), 0, 1, {1'b1, 6'd9}, 17'd18, 0, 0, 1, 0);
        add_idle(0, 0, 0, 0, 0, 1);
        add_idle(0, 0, 1, 0, 0, 1);
        add_idle(0, 0, 0, 0, 0, 0);
        add_idle(0, 1, 1, 0, 0, 0);
        add_idle(0, 0, 0, 0, 0, 1);
        add_idle(0, 0, 1, 0, 0, 1);
        add_idle(0, 0, 0, 0, 0, 0);
        // Restart from WAIT_OUT, then a clean frame still in bank 1 ending with a back-to-back ibstart
        add_idle(1, 0, 0, 0, 0, 0);
        add_idle(0, 1, 0, 0, 1, 0);
        add_idle(1, 0, 0, 0, 1, 0);
        add_idle(0, 1, 0, 0, 1, 1);
        add_bins(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add_idle(0, 1, 0, 1, 1, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].ib, tbl[i].ie, tbl[i].ob, tbl[i].ov, tbl[i].n,
                  tbl[i].re, tbl[i].im, tbl[i].clr);
            @(negedge Clock);
            ok = (wr_en === tbl[i].we) && (rd_bank === tbl[i].rb) &&
                 (frame_ready === tbl[i].fr) && (busy === tbl[i].bz) &&
                 (seq_err === tbl[i].se) &&
                 (!tbl[i].we || (wr_addr === tbl[i].wa && wr_data === tbl[i].wd));
            nvec++;
            if (!ok) begin
                nmiss++;
                $display("FAIL row %0d: got we=%b wa=%h wd=%h rb=%b fr=%b bz=%b se=%b, expected we=%b wa=%h wd=%h rb=%b fr=%b bz=%b se=%b",
                         i, wr_en, wr_addr, wr_data, rd_bank, frame_ready, busy, seq_err,
                         tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rb, tbl[i].fr, tbl[i].bz, tbl[i].se);
            end
            tick();
        end

        // Reset while unloading bin 30 of a bank-0 frame
        for (int k = 0; k <= 30; k++) begin
            drive(0, 0, k == 0, 1, 6'(k), 16'(k), 16'(-k), 0);
            @(negedge Clock);
            if (k == 30) begin
                chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
                chk("pre_rst_wr_addr", 32'(wr_addr), 32'h1d);
                chk("pre_rst_rd_bank", 32'(rd_bank), 32'd1);
                nReset = 1'b0;
                #1;
                chk("rst_wr_en", 32'(wr_en), 32'd0);
                chk("rst_rd_bank", 32'(rd_bank), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_seq_err", 32'(seq_err), 32'd0);
            end
            tick();
        end
        drive(0, 0, 0, 0, 6'd0, 16'd0, 16'd0, 0);
        tick();
        nReset = 1'b1;
        tick();

`ifdef FFTRX_PEAK_EN
        chk("peak_bin_reset", 32'(peak_bin), 32'd0);
        chk("peak_mag_reset", 32'(peak_mag), 32'd0);
        drive(1, 0, 0, 0, 6'd0, 16'd0, 16'd0, 0);
        tick();
        drive(0, 1, 0, 0, 6'd0, 16'd0, 16'd0, 0);
        tick();
        for (int k = 0; k < 64; k++) begin
            drive(0, 0, k == 0, 1, 6'(k), (k == 12 || k == 40) ? 16'd900 : 16'(k), 16'd0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 6'd0, 16'd0, 16'd0, 0);
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (frame_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("peak_frame_ready", 32'(got), 32'd1);
        chk("peak_bin", 32'(peak_bin), 32'd12);
        chk("peak_mag", 32'(peak_mag), 32'd900);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
